// File: rtl/skew_buf_pkg.sv
// Shared types and helpers for the skewed operand buffer.
//   state_t   : stream engine states
//   idx_width : index width for a DIM-entry dimension (never below 1 bit)
package skew_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_operand_buffer_if.sv
// Bus bundle for skew_operand_buffer.
//   slave  : the buffer (takes writes/start/enable, drives lanes and status)
//   master : the driver of the buffer (controller or testbench)
//   en        global enable, 0 stalls the stream engine
//   wr_en     row write strobe, wr_row row index, wr_data row (element j -> column j)
//   start     begin streaming, col_mode 0: lane i = row i, 1: lane i = column i
//   dout      skewed lane data, dvalid per-lane valid
//   busy      streaming in progress, done one-cycle pulse on the final element
interface skew_operand_buffer_if
  import skew_buf_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIM  = 8
);
  localparam int ROWW = idx_width(DIM);

  logic                          en;
  logic                          wr_en;
  logic [ROWW-1:0]               wr_row;
  logic [DIM-1:0][BITS-1:0]      wr_data;
  logic                          start;
  logic                          col_mode;
  logic [DIM-1:0][BITS-1:0]      dout;
  logic [DIM-1:0]                dvalid;
  logic                          busy;
  logic                          done;

  modport slave (
    input  en, wr_en, wr_row, wr_data, start, col_mode,
    output dout, dvalid, busy, done
  );

  modport master (
    output en, wr_en, wr_row, wr_data, start, col_mode,
    input  dout, dvalid, busy, done
  );

endinterface

// File: rtl/skew_delay_line.sv
// Data + valid shift register used to skew one output lane.
//   clk, rst : clock, synchronous active-high reset
//   en       : shift enable; 0 holds every stage
//   din, vin : stage-0 input; data is forced to 0 when vin=0
//   dout,vout: last stage (DEPTH+1 register stages in total, so DEPTH=0 is a
//              single output register)
module skew_delay_line #(
  parameter int BITS  = 8,
  parameter int DEPTH = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] din,
  input  logic            vin,
  output logic [BITS-1:0] dout,
  output logic            vout
);

  logic [DEPTH:0][BITS-1:0] data_q, data_d;
  logic [DEPTH:0]           vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en) begin
      // Zeroing invalid data keeps lanes at 0 outside their window.
      data_d[0] = vin ? din : '0;
      vld_d[0]  = vin;
      for (int s = 1; s <= DEPTH; s++) begin
        data_d[s] = data_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = data_q[DEPTH];
  assign vout = vld_q[DEPTH];

endmodule

// File: rtl/skew_operand_buffer.sv
// DIM x DIM operand tile store with a diagonally skewed streaming engine.
//   clk, rst : clock, synchronous active-high reset (clears tile and stream)
//   bus      : skew_operand_buffer_if.slave (writes, start/mode, lanes, status)
//
// state  | meaning
// IDLE   | waiting for start; row writes accepted while busy=0
// STREAM | step k = 0..DIM-1 feeds element k of every lane into its delay line
// DRAIN  | DIM-1 cycles letting the deepest delay line empty; done on the last
module skew_operand_buffer
  import skew_buf_pkg::*;
#(
  parameter  int BITS = 8,
  parameter  int DIM  = 8,
  localparam int ROWW = idx_width(DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  skew_operand_buffer_if.slave  bus
);

  logic [DIM-1:0][DIM-1:0][BITS-1:0] mem_q, mem_d;
  state_t                            state_q, state_d;
  logic [ROWW-1:0]                   step_q, step_d;
  logic                              col_mode_q, col_mode_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [DIM-1:0][BITS-1:0]          lane_in;
  logic                              lane_vld;

  // Writes ignore en but are locked out while the visible busy flag is high.
  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en && !busy_q && (int'(bus.wr_row) < DIM)) begin
      mem_d[bus.wr_row] = bus.wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    col_mode_d = col_mode_q;
    busy_d     = busy_q;
    done_d     = done_q;
    if (bus.en) begin
      // busy lags the FSM by one edge, so it stays up through the done cycle.
      busy_d = (state_q != IDLE);
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d    = STREAM;
            step_d     = '0;
            col_mode_d = bus.col_mode;
          end
        end
        STREAM: begin
          if (step_q == ROWW'(DIM - 1)) begin
            state_d = DRAIN;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        DRAIN: begin
          if (step_q == ROWW'(DIM - 2)) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    lane_vld = (state_q == STREAM);
    lane_in  = '0;
    for (int i = 0; i < DIM; i++) begin
      lane_in[i] = col_mode_q ? mem_q[step_q][i] : mem_q[i][step_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      state_q    <= IDLE;
      step_q     <= '0;
      col_mode_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      step_q     <= step_d;
      col_mode_q <= col_mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_delay_line #(
      .BITS  (BITS),
      .DEPTH (i)
    ) u_dl (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .din  (lane_in[i]),
      .vin  (lane_vld),
      .dout (bus.dout[i]),
      .vout (bus.dvalid[i])
    );
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_skew_operand_buffer.sv
module tb_skew_operand_buffer;
  import skew_buf_pkg::*;

  localparam int BITS = 8;
  localparam int DIM  = 8;
  localparam int ROWW = idx_width(DIM);
  localparam int OUTW = DIM*BITS + DIM + 2;
  localparam int SPAN = 2*DIM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skew_operand_buffer_if #(.BITS(BITS), .DIM(DIM)) bus ();

  skew_operand_buffer #(.BITS(BITS), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference tile as the stream should see it.
  logic [BITS-1:0] mdl_mem [DIM][DIM];

  // Expected {dout, dvalid, busy, done} after the t-th enabled edge past start.
  function automatic logic [OUTW-1:0] model_at(input int t, input bit mode);
    logic [DIM-1:0][BITS-1:0] d;
    logic [DIM-1:0]           v;
    d = '0;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      int k;
      k = t - 1 - i;
      if (k >= 0 && k < DIM) begin
        v[i] = 1'b1;
        d[i] = mode ? mdl_mem[k][i] : mdl_mem[i][k];
      end
    end
    return {d, v, (t >= 1 && t <= SPAN-1), (t == SPAN-1)};
  endfunction

  function automatic logic [OUTW-1:0] observed();
    return {bus.dout, bus.dvalid, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b1; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.col_mode = 1'b0;
  endtask

  task automatic write_row(input int r, input logic [DIM-1:0][BITS-1:0] d);
    bus.wr_en = 1'b1; bus.wr_row = ROWW'(r); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    for (int c = 0; c < DIM; c++) mdl_mem[r][c] = d[c];
  endtask

  task automatic load_ramp();
    logic [DIM-1:0][BITS-1:0] d;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) d[c] = BITS'(r*DIM + c);
      write_row(r, d);
    end
  endtask

  task automatic load_random();
    logic [DIM-1:0][BITS-1:0] d;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) d[c] = BITS'($urandom);
      write_row(r, d);
    end
  endtask

  // Start pulse is sampled at E0; col_mode is flipped afterwards to prove latching.
  task automatic start_stream(input bit mode);
    bus.start = 1'b1; bus.col_mode = mode;
    tick();
    bus.start = 1'b0; bus.col_mode = ~mode;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", observed());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL reset_release got=%h exp=0", observed());
    end
  endtask

  task automatic test_row_stream();
    logic [OUTW-1:0] e;
    load_ramp();
    start_stream(1'b0);
    for (int t = 1; t <= SPAN; t++) begin
      tick();
      e = model_at(t, 1'b0);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL row_stream t=%0d got=%h exp=%h", t, observed(), e);
      end
      if (t == 1) begin
        checks++;
        if (bus.dout[0] !== 8'd0 || bus.dvalid !== 8'b0000_0001) begin
          errors++; $display("FAIL row_e1 got=%h/%b exp=00/00000001", bus.dout[0], bus.dvalid);
        end
      end
      if (t == 3) begin
        checks++;
        if (bus.dout[2] !== 8'd16 || bus.dout[1] !== 8'd9) begin
          errors++; $display("FAIL row_e3 got=%0d,%0d exp=16,9", bus.dout[2], bus.dout[1]);
        end
      end
      if (t == 15) begin
        checks++;
        if (bus.dout[7] !== 8'd63 || bus.done !== 1'b1) begin
          errors++; $display("FAIL row_e15 got=%0d done=%b exp=63 done=1", bus.dout[7], bus.done);
        end
      end
      if (t == 16) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++; $display("FAIL row_e16_busy got=%b exp=0", bus.busy);
        end
      end
    end
  endtask

  task automatic test_col_mode();
    logic [OUTW-1:0] e;
    start_stream(1'b1);
    for (int t = 1; t <= SPAN; t++) begin
      tick();
      e = model_at(t, 1'b1);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL col_stream t=%0d got=%h exp=%h", t, observed(), e);
      end
      if (t >= 4 && t <= 11) begin
        checks++;
        if (bus.dout[3] !== BITS'(8*(t-4) + 3) || bus.dvalid[3] !== 1'b1) begin
          errors++; $display("FAIL col_lane3 t=%0d got=%0d exp=%0d", t, bus.dout[3], 8*(t-4)+3);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [OUTW-1:0] e;
    int t, hold;
    bit ena;
    t = 0; hold = 0;
    start_stream(1'b0);
    for (int cyc = 0; cyc < 4*SPAN && t < SPAN; cyc++) begin
      ena = !(t == 5 && hold < 3);
      if (!ena) hold++;
      bus.en = ena;
      tick();
      if (ena) t++;
      e = model_at(t, 1'b0);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL stall cyc=%0d t=%0d got=%h exp=%h", cyc, t, observed(), e);
      end
    end
    bus.en = 1'b1;
    checks++;
    if (t != SPAN || hold != 3) begin
      errors++; $display("FAIL stall_progress got t=%0d hold=%0d exp t=%0d hold=3", t, hold, SPAN);
    end
  endtask

  task automatic test_random();
    logic [OUTW-1:0] e;
    int t;
    bit ena, mode;
    for (int it = 0; it < 4; it++) begin
      load_random();
      mode = 1'($urandom);
      t = 0;
      start_stream(mode);
      for (int cyc = 0; cyc < 6*SPAN && t < SPAN; cyc++) begin
        ena = ($urandom_range(3) != 0);
        bus.en = ena;
        bus.wr_en = (t >= 1 && t <= SPAN-1) ? 1'($urandom) : 1'b0;
        bus.wr_row = ROWW'($urandom);
        for (int c = 0; c < DIM; c++) bus.wr_data[c] = BITS'($urandom);
        bus.start = (t <= SPAN-2) ? 1'($urandom) : 1'b0;
        tick();
        if (ena) t++;
        e = model_at(t, mode);
        checks++;
        if (observed() !== e) begin
          errors++; $display("FAIL random it=%0d t=%0d got=%h exp=%h", it, t, observed(), e);
        end
      end
      idle_inputs();
      checks++;
      if (t != SPAN) begin
        errors++; $display("FAIL random_timeout it=%0d got t=%0d exp %0d", it, t, SPAN);
      end
    end
  endtask

  task automatic test_write_busy();
    logic [OUTW-1:0] e;
    load_ramp();
    for (int pass = 0; pass < 2; pass++) begin
      start_stream(1'b0);
      for (int t = 1; t <= SPAN; t++) begin
        bus.wr_en = (pass == 0 && t == 3);
        bus.wr_row = '0;
        bus.wr_data = {DIM{8'h7F}};
        tick();
        bus.wr_en = 1'b0;
        e = model_at(t, 1'b0);
        checks++;
        if (observed() !== e) begin
          errors++; $display("FAIL write_busy pass=%0d t=%0d got=%h exp=%h", pass, t, observed(), e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [OUTW-1:0] e;
    load_ramp();
    start_stream(1'b0);
    for (int t = 1; t <= 5; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_mem[r][c] = '0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (observed() !== '0) begin
        errors++; $display("FAIL reset_mid n=%0d got=%h exp=0", n, observed());
      end
      tick();
    end
    start_stream(1'b1);
    for (int t = 1; t <= SPAN; t++) begin
      tick();
      e = model_at(t, 1'b1);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL reset_zero_stream t=%0d got=%h exp=%h", t, observed(), e);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [OUTW-1:0] e;
    logic [DIM-1:0][BITS-1:0] d;
    for (int c = 0; c < DIM; c++) d[c] = BITS'(-(c+1));
    bus.wr_en = 1'b1; bus.wr_row = '0; bus.wr_data = d;
    bus.start = 1'b1; bus.col_mode = 1'b0;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    for (int c = 0; c < DIM; c++) mdl_mem[0][c] = d[c];
    for (int t = 1; t <= SPAN; t++) begin
      tick();
      e = model_at(t, 1'b0);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL same_cycle t=%0d got=%h exp=%h", t, observed(), e);
      end
      if (t == 1) begin
        checks++;
        if ($signed(bus.dout[0]) !== -8'sd1) begin
          errors++; $display("FAIL same_cycle_lane0 got=%0d exp=-1", $signed(bus.dout[0]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OUTW-1:0] e;
    load_random();
    bus.start = 1'b1; bus.col_mode = 1'b0;
    tick();
    for (int n = 1; n <= 2*SPAN; n++) begin
      tick();
      if (n == SPAN) bus.start = 1'b0;
      e = (n < SPAN) ? model_at(n, 1'b0) : model_at(n - SPAN, 1'b0);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL back_to_back n=%0d got=%h exp=%h", n, observed(), e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_row_stream();
    test_col_mode();
    test_stall();
    test_random();
    test_write_busy();
    test_reset_mid();
    test_same_cycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
